uart_tx_frame: RTL and testbench

- UART transmitter framing block; transmit-side counterpart of the Rx parity checker and deserializer.
- Accepts a parallel byte, generates even/odd parity using the same parity_type encoding as the Rx side, and serializes the frame onto tx_out.
- Frame order: start, data LSB-first, optional parity, stop.
- Sits between the Tx host interface and the pad; clock is the Tx bit-rate reference, divided internally by CLKS_PER_BIT.

---
 rtl/uart_tx_frame.sv | 184 ++++++++++++++++++
 tb/tb_uart_tx_frame.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmit framer.
// Latches a parallel word and serializes it as start bit, data (LSB first),
// optional even/odd parity bit and stop bit(s). Every line bit is held for
// CLKS_PER_BIT clocks. tx_out and busy are registered outputs.
// Optional build macro UART_TX_TWO_STOP_EN: send two stop bits instead of one.
module uart_tx_frame #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  input  logic                  parity_enable,
  input  logic                  parity_type,
  output logic                  tx_out,
  output logic                  busy
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

`ifdef UART_TX_TWO_STOP_EN
  localparam int unsigned STOP_BITS = 2;
`else
  localparam int unsigned STOP_BITS = 1;
`endif

  localparam logic [CNT_W-1:0] LAST_CYCLE = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_DATA  = IDX_W'(DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0] LAST_STOP  = IDX_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } txState_t;

  txState_t              r_state;
  txState_t              w_nextState;
  logic [CNT_W-1:0]      r_cycleCnt;
  logic [CNT_W-1:0]      w_nextCycleCnt;
  logic [IDX_W-1:0]      r_bitIdx;
  logic [IDX_W-1:0]      w_nextBitIdx;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] w_nextShift;
  logic                  r_parity;
  logic                  w_nextParity;
  logic                  r_parityEn;
  logic                  w_nextParityEn;
  logic                  w_bitDone;
  logic                  w_txNext;
  logic                  w_busyNext;

  // Last clock of the current line bit.
  assign w_bitDone = (r_cycleCnt == LAST_CYCLE);

  // State register; an asserted reset abandons any frame in progress.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and datapath update: bit timing, data shifting, accept-time latching.
  always_comb begin
    w_nextState    = r_state;
    w_nextCycleCnt = w_bitDone ? '0 : (r_cycleCnt + CNT_W'(1));
    w_nextBitIdx   = r_bitIdx;
    w_nextShift    = r_shift;
    w_nextParity   = r_parity;
    w_nextParityEn = r_parityEn;

    case (r_state)
      IDLE: begin
        w_nextCycleCnt = '0;
        w_nextBitIdx   = '0;
        if (data_valid) begin
          w_nextState    = START;
          w_nextShift    = data_in;
          w_nextParity   = parity_type ? ~(^data_in) : (^data_in);
          w_nextParityEn = parity_enable;
        end
      end

      START: begin
        if (w_bitDone) begin
          w_nextState  = DATA;
          w_nextBitIdx = '0;
        end
      end

      DATA: begin
        if (w_bitDone) begin
          w_nextShift = r_shift >> 1;
          if (r_bitIdx == LAST_DATA) begin
            w_nextBitIdx = '0;
            w_nextState  = r_parityEn ? PARITY : STOP;
          end else begin
            w_nextBitIdx = r_bitIdx + IDX_W'(1);
          end
        end
      end

      PARITY: begin
        if (w_bitDone) begin
          w_nextState  = STOP;
          w_nextBitIdx = '0;
        end
      end

      STOP: begin
        if (w_bitDone) begin
          if (r_bitIdx == LAST_STOP) begin
            w_nextState  = IDLE;
            w_nextBitIdx = '0;
          end else begin
            w_nextBitIdx = r_bitIdx + IDX_W'(1);
          end
        end
      end

      default: begin
        w_nextState    = IDLE;
        w_nextCycleCnt = '0;
        w_nextBitIdx   = '0;
      end
    endcase
  end

  // Line level and busy for the upcoming cycle, looked up from the next state so the outputs can be registered.
  always_comb begin
    w_txNext   = 1'b1;
    w_busyNext = 1'b0;
    case (w_nextState)
      START: begin
        w_txNext   = 1'b0;
        w_busyNext = 1'b1;
      end
      DATA: begin
        w_txNext   = w_nextShift[0];
        w_busyNext = 1'b1;
      end
      PARITY: begin
        w_txNext   = r_parity;
        w_busyNext = 1'b1;
      end
      STOP: begin
        w_txNext   = 1'b1;
        w_busyNext = 1'b1;
      end
      default: begin
        w_txNext   = 1'b1;
        w_busyNext = 1'b0;
      end
    endcase
  end

  // Datapath and output registers; reset forces an idle-high line at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cycleCnt <= '0;
      r_bitIdx   <= '0;
      r_shift    <= '0;
      r_parity   <= 1'b0;
      r_parityEn <= 1'b0;
      tx_out     <= 1'b1;
      busy       <= 1'b0;
    end else begin
      r_cycleCnt <= w_nextCycleCnt;
      r_bitIdx   <= w_nextBitIdx;
      r_shift    <= w_nextShift;
      r_parity   <= w_nextParity;
      r_parityEn <= w_nextParityEn;
      tx_out     <= w_txNext;
      busy       <= w_busyNext;
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: directed bench for uart_tx_frame with one instance at
// CLKS_PER_BIT=1 and one at CLKS_PER_BIT=4. Expected line bits are written
// out by hand per frame (bit 0 of each vector is the first bit on the line).
module tb_uart_tx_frame;

`ifdef UART_TX_TWO_STOP_EN
  localparam int STOP_EXTRA = 1;
`else
  localparam int STOP_EXTRA = 0;
`endif

  logic       clock;
  logic       reset;

  logic [7:0] d1Data;
  logic       d1Valid;
  logic       d1Pe;
  logic       d1Pt;
  logic       tx1;
  logic       busy1;

  logic [7:0] d4Data;
  logic       d4Valid;
  logic       d4Pe;
  logic       d4Pt;
  logic       tx4;
  logic       busy4;

  int checks;
  int failures;

  uart_tx_frame #(.DATA_WIDTH(8), .CLKS_PER_BIT(1)) dut1 (
    .clock         (clock),
    .reset         (reset),
    .data_in       (d1Data),
    .data_valid    (d1Valid),
    .parity_enable (d1Pe),
    .parity_type   (d1Pt),
    .tx_out        (tx1),
    .busy          (busy1)
  );

  uart_tx_frame #(.DATA_WIDTH(8), .CLKS_PER_BIT(4)) dut4 (
    .clock         (clock),
    .reset         (reset),
    .data_in       (d4Data),
    .data_valid    (d4Valid),
    .parity_enable (d4Pe),
    .parity_type   (d4Pt),
    .tx_out        (tx4),
    .busy          (busy4)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Present a word on the selected instance at a falling edge; it is accepted on the following rising edge.
  task automatic applyStimulus(input bit sel, input logic [7:0] data, input logic pe, input logic pt);
    @(negedge clock);
    if (sel) begin
      d4Data = data; d4Pe = pe; d4Pt = pt; d4Valid = 1'b1;
    end else begin
      d1Data = data; d1Pe = pe; d1Pt = pt; d1Valid = 1'b1;
    end
    @(posedge clock);
  endtask

  // Drop data_valid (unless held) and optionally fire a one-cycle 0xFF request mid-frame.
  task automatic manageValid(input bit sel, input int cyc, input int pulseAt, input bit holdValid);
    if (!holdValid) begin
      if (sel) d4Valid = 1'b0; else d1Valid = 1'b0;
    end
    if (cyc == pulseAt) begin
      if (sel) begin
        d4Data = 8'hFF; d4Pe = 1'b0; d4Pt = 1'b0; d4Valid = 1'b1;
      end else begin
        d1Data = 8'hFF; d1Pe = 1'b0; d1Pt = 1'b0; d1Valid = 1'b1;
      end
    end
  endtask

  // Walk one frame at falling edges, starting the half cycle after the accepting edge, then check the idle cycle after it.
  task automatic checkFrame(input bit sel, input logic [15:0] bits, input int len,
                            input int pulseAt, input bit holdValid, input string tag);
    int cpb;
    int cyc;
    cpb = sel ? 4 : 1;
    cyc = 0;
    for (int i = 0; i < len; i++) begin
      for (int c = 0; c < cpb; c++) begin
        @(negedge clock);
        manageValid(sel, cyc, pulseAt, holdValid);
        checkOutput($sformatf("%s bit%0d cyc%0d tx", tag, i, c), sel ? tx4 : tx1, bits[i]);
        checkOutput($sformatf("%s bit%0d cyc%0d busy", tag, i, c), sel ? busy4 : busy1, 1'b1);
        cyc++;
      end
    end
    for (int c = 0; c < STOP_EXTRA * cpb; c++) begin
      @(negedge clock);
      manageValid(sel, cyc, pulseAt, holdValid);
      checkOutput($sformatf("%s stop2 cyc%0d tx", tag, c), sel ? tx4 : tx1, 1'b1);
      checkOutput($sformatf("%s stop2 cyc%0d busy", tag, c), sel ? busy4 : busy1, 1'b1);
      cyc++;
    end
    @(negedge clock);
    manageValid(sel, cyc, pulseAt, holdValid);
    checkOutput($sformatf("%s idle tx", tag), sel ? tx4 : tx1, 1'b1);
    checkOutput($sformatf("%s idle busy", tag), sel ? busy4 : busy1, 1'b0);
  endtask

  // Directed sequence covering reset, parity modes, bit timing, mid-frame requests, streaming and reset abort.
  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    d1Data = 8'h00; d1Valid = 1'b0; d1Pe = 1'b0; d1Pt = 1'b0;
    d4Data = 8'h00; d4Valid = 1'b0; d4Pe = 1'b0; d4Pt = 1'b0;

    repeat (2) @(negedge clock);
    checkOutput("reset tx1", tx1, 1'b1);
    checkOutput("reset busy1", busy1, 1'b0);
    checkOutput("reset tx4", tx4, 1'b1);
    checkOutput("reset busy4", busy4, 1'b0);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checkOutput("idle tx1", tx1, 1'b1);
    checkOutput("idle busy1", busy1, 1'b0);

    // 0xA5 even parity: 0,1,0,1,0,0,1,0,1,0,1
    applyStimulus(1'b0, 8'hA5, 1'b1, 1'b0);
    checkFrame(1'b0, 16'b101_0100_1010, 11, -1, 1'b0, "A5even");

    // 0x07 odd parity: 0,1,1,1,0,0,0,0,0,0,1
    applyStimulus(1'b0, 8'h07, 1'b1, 1'b1);
    checkFrame(1'b0, 16'b100_0000_1110, 11, -1, 1'b0, "07odd");

    // 0x07 even parity: parity slot becomes 1
    applyStimulus(1'b0, 8'h07, 1'b1, 1'b0);
    checkFrame(1'b0, 16'b110_0000_1110, 11, -1, 1'b0, "07even");

    // 0x00 without parity: 0, eight 0s, 1
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkFrame(1'b0, 16'b10_0000_0000, 10, -1, 1'b0, "00nopar");

    // 0x5A even parity at 4 clocks per bit: 0,0,1,0,1,1,0,1,0,0,1
    applyStimulus(1'b1, 8'h5A, 1'b1, 1'b0);
    checkFrame(1'b1, 16'b100_1011_0100, 11, -1, 1'b0, "5Acpb4");

    // 0x12 odd parity with a 0xFF request pulsed mid-frame: 0,0,1,0,0,1,0,0,0,1,1
    applyStimulus(1'b0, 8'h12, 1'b1, 1'b1);
    checkFrame(1'b0, 16'b110_0010_0100, 11, 4, 1'b0, "12pulse");
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      checkOutput($sformatf("noFF tx k%0d", k), tx1, 1'b1);
      checkOutput($sformatf("noFF busy k%0d", k), busy1, 1'b0);
    end

    // 0x33 no parity with data_valid held: 0,1,1,0,0,1,1,0,0,1 twice, one idle cycle between
    applyStimulus(1'b0, 8'h33, 1'b0, 1'b0);
    checkFrame(1'b0, 16'b10_0110_0110, 10, -1, 1'b1, "33first");
    checkFrame(1'b0, 16'b10_0110_0110, 10, -1, 1'b1, "33second");
    d1Valid = 1'b0;
    repeat (2) @(negedge clock);
    checkOutput("stream end busy", busy1, 1'b0);

    // Abort 0xA5 during data bit 3 (a 0 on the line) with reset
    applyStimulus(1'b0, 8'hA5, 1'b1, 1'b0);
    @(negedge clock);
    d1Valid = 1'b0;
    repeat (4) @(negedge clock);
    checkOutput("pre-abort tx", tx1, 1'b0);
    checkOutput("pre-abort busy", busy1, 1'b1);
    reset = 1'b0;
    #1;
    checkOutput("abort tx", tx1, 1'b1);
    checkOutput("abort busy", busy1, 1'b0);
    @(negedge clock);
    checkOutput("abort hold tx", tx1, 1'b1);
    checkOutput("abort hold busy", busy1, 1'b0);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("post-abort idle busy", busy1, 1'b0);

    // Clean frame after the abort
    applyStimulus(1'b0, 8'h07, 1'b1, 1'b1);
    checkFrame(1'b0, 16'b100_0000_1110, 11, -1, 1'b0, "post-abort 07odd");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
